// File: rtl/prover_sum_h.sv
// prover_sum_h: sums the per-gate gamma-point products held upstream into
// V_{i+1}(gamma(t)) for t = 2..npoints-1; points 0 and 1 are loaded at start.
// Build option: define PROVER_SUM_H_SERIAL_EN to use one sequential field_adder
// in place of the pairwise reduction tree (same results and handshake).

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1fff_ffff_ffff_ffff
`endif

// Modular adder with one register stage: en in cycle n gives sum/ready_pulse in n+1.
module field_adder #(
  parameter int unsigned W = `F_NBITS
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ready_pulse
);
  localparam int unsigned WQ = W + 1;
  localparam logic [W:0]  Q  = WQ'(`F_Q);

  logic [W:0]   raw_c;
  logic [W-1:0] sum_d;

  // a + b folded back below Q (inputs are already reduced)
  always_comb begin
    raw_c = {1'b0, a} + {1'b0, b};
    sum_d = (raw_c >= Q) ? W'(raw_c - Q) : W'(raw_c);
  end

  // result and completion strobe
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sum         <= '0;
      ready_pulse <= 1'b0;
    end else begin
      ready_pulse <= en;
      if (en) sum <= sum_d;
    end
  end
endmodule

module prover_sum_h #(
  parameter  int unsigned ngates  = 8,
  localparam int unsigned npoints = $clog2(ngates) + 1,
  localparam int unsigned nlevels = $clog2(ngates)
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  en,
  input  logic [`F_NBITS-1:0]                   v_w1,
  input  logic [`F_NBITS-1:0]                   v_w2,
  output logic                                  p_rden,
  input  logic [ngates-1:0][`F_NBITS-1:0]       p_in,
  output logic                                  ready,
  output logic                                  ready_pulse,
  output logic [npoints-1:0][`F_NBITS-1:0]      h_out
);
  localparam int unsigned W  = `F_NBITS;
  localparam int unsigned IW = nlevels;
  localparam int unsigned CW = nlevels + 1;
  localparam int unsigned PW = $clog2(npoints);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_GO, S_WAIT, S_STORE
  } state_t;

  state_t        state_q;
  logic          en_dly_q;
  logic          ready_dly_q;
  logic          ready_pulse_q;
  logic          p_rden_q;
  logic [PW-1:0] idx_q;
  logic [W-1:0]  h_q [npoints];
  logic [W-1:0]  r_q [ngates];
  logic          idle_c;
  logic          start_c;

  assign idle_c      = (state_q == S_IDLE);
  assign start_c     = en & ~en_dly_q & idle_c;
  assign ready       = idle_c & ~start_c;
  assign ready_pulse = ready_pulse_q;
  assign p_rden      = p_rden_q;

  for (genvar t = 0; t < npoints; t++) begin : g_hout
    assign h_out[t] = h_q[t];
  end

`ifdef PROVER_SUM_H_SERIAL_EN
  logic [IW-1:0] j_q;
  logic          done_q;
  logic          add_en_c;
  logic          add_pls;
  logic [W-1:0]  add_sum;

  assign add_en_c = (state_q == S_GO);

  // accumulator lives in r_q[0]; r_q[j] is added on each step
  field_adder #(.W(W)) u_add (
    .clk(clk), .rstb(rstb), .en(add_en_c), .a(r_q[0]), .b(r_q[j_q]),
    .sum(add_sum), .ready_pulse(add_pls)
  );
`else
  localparam int unsigned NADD = ngates / 2;

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   half_c;
  logic [CW-1:0]   cnt_nxt_c;
  logic [NADD-1:0] done_q;
  logic [NADD-1:0] act_c;
  logic [NADD-1:0] add_en_c;
  logic [NADD-1:0] add_pls;
  logic [W-1:0]    add_sum [NADD];
  logic            all_done_c;

  assign half_c     = cnt_q >> 1;
  assign cnt_nxt_c  = (cnt_q + CW'(1)) >> 1;
  assign all_done_c = &(done_q | ~act_c);
  assign add_en_c   = act_c & {NADD{state_q == S_GO}};

  // adder k reduces pair (2k, 2k+1) while k < cnt/2
  for (genvar k = 0; k < NADD; k++) begin : g_add
    assign act_c[k] = (CW'(k) < half_c);
    field_adder #(.W(W)) u_add (
      .clk(clk), .rstb(rstb), .en(add_en_c[k]), .a(r_q[2*k]), .b(r_q[2*k+1]),
      .sum(add_sum[k]), .ready_pulse(add_pls[k])
    );
  end
`endif

  // control FSM, handshake registers and result storage
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= S_IDLE;
      en_dly_q      <= 1'b1;
      ready_dly_q   <= 1'b1;
      ready_pulse_q <= 1'b0;
      p_rden_q      <= 1'b0;
      idx_q         <= '0;
      done_q        <= '0;
      for (int t = 0; t < npoints; t++) h_q[t] <= '0;
      for (int g = 0; g < ngates; g++) r_q[g] <= '0;
`ifdef PROVER_SUM_H_SERIAL_EN
      j_q           <= '0;
`else
      cnt_q         <= '0;
`endif
    end else begin
      en_dly_q      <= en;
      ready_dly_q   <= ready;
      ready_pulse_q <= ready & ~ready_dly_q;
      p_rden_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            h_q[0]   <= v_w1;
            h_q[1]   <= v_w2;
            idx_q    <= PW'(2);
            p_rden_q <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: state_q <= S_LATCH;
        S_LATCH: begin
          for (int g = 0; g < ngates; g++) r_q[g] <= p_in[g];
`ifdef PROVER_SUM_H_SERIAL_EN
          j_q   <= IW'(1);
`else
          cnt_q <= CW'(ngates);
`endif
          state_q <= S_GO;
        end
        S_GO: begin
          done_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
`ifdef PROVER_SUM_H_SERIAL_EN
          if (add_pls) done_q <= 1'b1;
          if (done_q) begin
            r_q[0] <= add_sum;
            if (j_q == IW'(ngates - 1)) begin
              state_q <= S_STORE;
            end else begin
              j_q     <= j_q + IW'(1);
              state_q <= S_GO;
            end
          end
`else
          done_q <= done_q | (add_pls & act_c);
          if (all_done_c) begin
            for (int k = 0; k < NADD; k++) begin
              if (act_c[k]) r_q[k] <= add_sum[k];
            end
            if (cnt_q[0]) r_q[IW'(half_c)] <= r_q[IW'(cnt_q - CW'(1))];
            cnt_q   <= cnt_nxt_c;
            state_q <= (cnt_nxt_c > CW'(1)) ? S_GO : S_STORE;
          end
`endif
        end
        S_STORE: begin
          h_q[idx_q] <= r_q[0];
          idx_q      <= idx_q + PW'(1);
          if (idx_q == PW'(npoints - 1)) begin
            state_q <= S_IDLE;
          end else begin
            p_rden_q <= 1'b1;
            state_q  <= S_READ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prover_sum_h.sv
// Bench for prover_sum_h: an 8-gate and a 5-gate instance, each fed by a
// ring-buffer model; expected point vectors go through a scoreboard queue.
`timescale 1ns/1ps

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1fff_ffff_ffff_ffff
`endif

module tb_prover_sum_h;
  localparam int unsigned W  = `F_NBITS;
  localparam logic [63:0] QM = 64'(`F_Q);
  localparam int G0  = 8;
  localparam int G1  = 5;
  localparam int NP0 = $clog2(G0) + 1;
  localparam int NP1 = $clog2(G1) + 1;
  localparam int LA  = 1;
`ifdef PROVER_SUM_H_SERIAL_EN
  localparam int PER0 = 3 + (G0 - 1) * (LA + 2);
  localparam int PER1 = 3 + (G1 - 1) * (LA + 2);
`else
  localparam int PER0 = 3 + $clog2(G0) * (LA + 2);
  localparam int PER1 = 3 + $clog2(G1) * (LA + 2);
`endif
  localparam int LIMIT = 1000;

  typedef struct {
    int           d;
    int           t;
    logic [W-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  logic en_s [2];
  logic [W-1:0] w1_s [2];
  logic [W-1:0] w2_s [2];
  logic rden [2];
  logic rdy  [2];
  logic rpls [2];
  logic [G0-1:0][W-1:0]  pin0;
  logic [G1-1:0][W-1:0]  pin1;
  logic [NP0-1:0][W-1:0] h0;
  logic [NP1-1:0][W-1:0] h1;

  logic [W-1:0] mem [2][8][8];
  int rd_cnt [2] = '{0, 0};
  int rp_cnt [2] = '{0, 0};
  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prover_sum_h #(.ngates(G0)) dut0 (
    .clk(clk), .rstb(rstb), .en(en_s[0]), .v_w1(w1_s[0]), .v_w2(w2_s[0]),
    .p_rden(rden[0]), .p_in(pin0), .ready(rdy[0]), .ready_pulse(rpls[0]), .h_out(h0)
  );
  prover_sum_h #(.ngates(G1)) dut1 (
    .clk(clk), .rstb(rstb), .en(en_s[1]), .v_w1(w1_s[1]), .v_w2(w2_s[1]),
    .p_rden(rden[1]), .p_in(pin1), .ready(rdy[1]), .ready_pulse(rpls[1]), .h_out(h1)
  );

  // upstream ring buffers: q follows rden by one cycle, pointer wraps at depth
  always @(posedge clk) begin
    if (rden[0] === 1'b1) begin
      for (int g = 0; g < G0; g++) pin0[g] <= mem[0][rd_cnt[0] % (NP0 - 2)][g];
      rd_cnt[0] <= rd_cnt[0] + 1;
    end
    if (rden[1] === 1'b1) begin
      for (int g = 0; g < G1; g++) pin1[g] <= mem[1][rd_cnt[1] % (NP1 - 2)][g];
      rd_cnt[1] <= rd_cnt[1] + 1;
    end
    if (rpls[0] === 1'b1) rp_cnt[0] <= rp_cnt[0] + 1;
    if (rpls[1] === 1'b1) rp_cnt[1] <= rp_cnt[1] + 1;
  end

  function automatic int np(input int d);
    return (d == 0) ? NP0 : NP1;
  endfunction
  function automatic int ng(input int d);
    return (d == 0) ? G0 : G1;
  endfunction
  function automatic int per(input int d);
    return (d == 0) ? PER0 : PER1;
  endfunction
  function automatic logic [W-1:0] get_h(input int d, input int t);
    if (d == 0) return h0[t];
    return h1[t];
  endfunction
  function automatic logic [W-1:0] rnd_f();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return W'(x % QM);
  endfunction

  // one full run on instance d; expectations queued before stimulus
  task automatic run_and_check(input int d, input logic [W-1:0] w1, input logic [W-1:0] w2,
                               input bit hold_en, input bit mid_pulse, input string tag);
    int base, rp0, cyc, depth;
    logic [63:0] acc;
    exp_t e;
    depth = np(d) - 2;
    base  = rd_cnt[d];
    rp0   = rp_cnt[d];
    e.d = d; e.t = 0; e.v = w1; sb.push_back(e);
    e.t = 1; e.v = w2; sb.push_back(e);
    for (int t = 2; t < np(d); t++) begin
      acc = 64'd0;
      for (int g = 0; g < ng(d); g++) acc = (acc + 64'(mem[d][(base + t - 2) % depth][g])) % QM;
      e.t = t; e.v = W'(acc); sb.push_back(e);
    end
    @(posedge clk); #1;
    w1_s[d] = w1; w2_s[d] = w2; en_s[d] = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy[d] !== 1'b0) begin errors++; $display("FAIL %s ready_drop: got %b want 0", tag, rdy[d]); end
    cyc = 0;
    while (rdy[d] !== 1'b1 && cyc < LIMIT) begin
      cyc++;
      if (!hold_en && cyc == 2) en_s[d] = 1'b0;
      if (mid_pulse && cyc == 6) begin en_s[d] = 1'b1; w1_s[d] = ~w1; w2_s[d] = ~w2; end
      if (mid_pulse && cyc == 8) en_s[d] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (cyc != 1 + depth * per(d)) begin
      errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, cyc, 1 + depth * per(d));
    end
    checks++;
    if (rpls[d] !== 1'b0) begin errors++; $display("FAIL %s pulse_early: got %b want 0", tag, rpls[d]); end
    @(negedge clk);
    checks++;
    if (rpls[d] !== 1'b1) begin errors++; $display("FAIL %s pulse: got %b want 1", tag, rpls[d]); end
    @(negedge clk);
    checks++;
    if (rpls[d] !== 1'b0 || rp_cnt[d] - rp0 != 1) begin
      errors++; $display("FAIL %s pulse_count: got %0d (now %b) want 1", tag, rp_cnt[d] - rp0, rpls[d]);
    end
    checks++;
    if (rd_cnt[d] - base != depth) begin
      errors++; $display("FAIL %s rden_count: got %0d want %0d", tag, rd_cnt[d] - base, depth);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (get_h(e.d, e.t) !== e.v) begin
        errors++; $display("FAIL %s h_out[%0d]: got %0d want %0d", tag, e.t, get_h(e.d, e.t), e.v);
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int d = 0; d < 2; d++) begin en_s[d] = 1'b0; w1_s[d] = '0; w2_s[d] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || rpls[d] !== 1'b0 || rden[d] !== 1'b0) begin
        errors++; $display("FAIL reset_ctl[%0d]: ready=%b pulse=%b rden=%b want 1/0/0", d, rdy[d], rpls[d], rden[d]);
      end
      for (int t = 0; t < np(d); t++) begin
        checks++;
        if (get_h(d, t) !== '0) begin errors++; $display("FAIL reset_h[%0d][%0d]: got %0d want 0", d, t, get_h(d, t)); end
      end
    end
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic test_const_points();
    for (int p = 0; p < NP0 - 2; p++)
      for (int g = 0; g < G0; g++) mem[0][p][g] = W'(p + 2);
    run_and_check(0, W'(5), W'(9), 1'b0, 1'b0, "const");
  endtask

  task automatic test_wrap();
    for (int p = 0; p < NP0 - 2; p++)
      for (int g = 0; g < G0; g++) mem[0][p][g] = '0;
    mem[0][(rd_cnt[0]) % (NP0 - 2)][0] = W'(QM - 64'd1);
    mem[0][(rd_cnt[0]) % (NP0 - 2)][1] = W'(1);
    run_and_check(0, W'(3), W'(4), 1'b0, 1'b0, "wrap");
    for (int g = 0; g < G0; g++) mem[0][rd_cnt[0] % (NP0 - 2)][g] = W'(QM - 64'd1 - 64'(g));
    run_and_check(0, W'(QM - 64'd1), W'(0), 1'b0, 1'b0, "wrap_all");
  endtask

  task automatic test_odd_gates();
    for (int p = 0; p < NP1 - 2; p++)
      for (int g = 0; g < G1; g++) mem[1][p][g] = W'(g + 1);
    run_and_check(1, W'(7), W'(11), 1'b0, 1'b0, "odd");
  endtask

  task automatic test_en_handling();
    int rd0;
    for (int p = 0; p < NP0 - 2; p++)
      for (int g = 0; g < G0; g++) mem[0][p][g] = rnd_f();
    run_and_check(0, rnd_f(), rnd_f(), 1'b0, 1'b1, "en_mid");
    run_and_check(0, rnd_f(), rnd_f(), 1'b1, 1'b0, "en_hold");
    rd0 = rd_cnt[0];
    repeat (6) @(negedge clk);
    checks++;
    if (rd_cnt[0] != rd0 || rdy[0] !== 1'b1) begin
      errors++; $display("FAIL en_hold_restart: rden=%0d ready=%b want 0/1", rd_cnt[0] - rd0, rdy[0]);
    end
    en_s[0] = 1'b0;
    @(negedge clk);
    run_and_check(0, rnd_f(), rnd_f(), 1'b0, 1'b0, "en_rearm");
  endtask

  task automatic test_reset_mid_run();
    int n, seen, rd0;
    @(posedge clk); #1;
    w1_s[0] = W'(21); w2_s[0] = W'(22); en_s[0] = 1'b1;
    n = 0; seen = 0;
    while (seen < 2 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (n == 2) en_s[0] = 1'b0;
      if (rden[0] === 1'b1) seen++;
    end
    en_s[0] = 1'b0;
    checks++;
    if (seen < 2) begin errors++; $display("FAIL abort_wait_rden: got %0d strobes want 2", seen); end
    repeat (3) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || rden[0] !== 1'b0) begin
      errors++; $display("FAIL abort_ctl: ready=%b rden=%b want 1/0", rdy[0], rden[0]);
    end
    for (int t = 0; t < NP0; t++) begin
      checks++;
      if (h0[t] !== '0) begin errors++; $display("FAIL abort_h[%0d]: got %0d want 0", t, h0[t]); end
    end
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    rd0 = rd_cnt[0];
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt[0] != rd0 || rdy[0] !== 1'b1) begin
      errors++; $display("FAIL abort_idle: rden=%0d ready=%b want 0/1", rd_cnt[0] - rd0, rdy[0]);
    end
    run_and_check(0, W'(31), W'(32), 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 3; rep++)
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < np(d) - 2; p++)
          for (int g = 0; g < ng(d); g++) mem[d][p][g] = rnd_f();
        run_and_check(d, rnd_f(), rnd_f(), 1'b0, 1'b0, "random");
      end
  endtask

  initial begin
    test_reset();
    test_const_points();
    test_wrap();
    test_odd_gates();
    test_en_handling();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
